// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard receiver with frame checking and a show-ahead scan-code FIFO.
// Define PS2_PARITY_CHECK_EN to enforce odd parity; otherwise only start/stop bits are checked.
module ps2_keyboard #(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       perr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]       clk_sync_q, dat_sync_q;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [TW-1:0]    to_q, to_d;
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             overflow_q, perr_q;
  logic [7:0]       mem_q [DEPTH];

  logic fall, sdata, stop_edge, frame_ok, push_req, push, pop, full, empty;

  // Index 0 is the newest sample; idle preset keeps reset from looking like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[1:0], ps2_data};
    end
  end

  assign fall      = clk_sync_q[2] & ~clk_sync_q[1];
  assign sdata     = dat_sync_q[2];
  assign stop_edge = fall && (bit_cnt_q == 4'd10);

  // shift_q holds {parity, data[7:0], start}; the stop bit is the live sample.
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = !shift_q[0] && sdata && (^shift_q[9:1]);
`else
    frame_ok = !shift_q[0] && sdata;
`endif
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_d      = to_q;
    if (fall) begin
      to_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
      end else begin
        shift_d   = {sdata, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d = 4'd0;
        to_d      = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end else begin
      to_d = '0;
    end
  end

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign push_req = stop_edge && frame_ok;
  assign pop      = rd_en && !empty;
  // A pop in the same cycle frees the slot that the push then fills.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= 4'd0;
      shift_q    <= 10'd0;
      to_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_q      <= to_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req && full && !pop) overflow_q <= 1'b1;
      if (stop_edge && !frame_ok)   perr_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shift_q[8:1];
  end

  assign ready    = !empty;
  assign data     = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign overflow = overflow_q;
  assign perr     = perr_q;

endmodule
